addsub_arbiter: RTL
===================

# addsub_arbiter

Round-robin arbiter and sequencer that shares one 5-bit two's-complement add/subtract datapath among NREQ requesters. It accepts one operation at a time over per-requester valid/ready handshakes and registers the operands. It executes the operation on the shared ripple add/sub core and returns the sum, the C4/C5 carries, the overflow flag and the overflow-corrected 6-bit result over a single valid/ready response channel tagged with the requester ID. It sits between the operand-issuing front ends and the adder datapath.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 5, operand width; the spec is written for W=5, and C4/C5 mean carry out of bit W-2 and bit W-1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has an operation pending
- req_ready  out  NREQ  one-hot grant; transfer occurs when valid[i]&ready[i]
- req_x  in  NREQ*W  operand X, requester i at [i*W +: W]
- req_y  in  NREQ*W  operand Y, same packing
- req_op  in  NREQ  0 = add (X+Y), 1 = subtract (X-Y)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  $clog2(NREQ)  index of the requester served
- rsp_sum  out  W  raw W-bit sum S
- rsp_c4  out  1  carry out of bit 3
- rsp_c5  out  1  carry out of bit 4
- rsp_ovf  out  1  signed overflow, E = C4^C5
- rsp_wide  out  W+1  exact signed result: {C5,S} if ovf, else {S[4],S}

## Operation
- FSM states:
  - IDLE: req_ready is the one-hot round-robin grant among asserted req_valid, searching from ptr upward with wrap. If any valid is asserted, the transfer happens at the edge: x, y, op and id are latched, and the FSM goes to EXEC.
  - EXEC: the core computes from the latched operands. S, C4, C5, ovf and wide are registered into the rsp_* registers, and the FSM goes to RESP.
  - RESP: rsp_valid=1 and the rsp_* outputs are stable. On rsp_ready=1: ptr <= id+1 (mod NREQ), and the FSM goes to IDLE.
- req_ready is all-zero outside IDLE. At most one bit is ever set.
- Subtract: Y is XORed bitwise with op and carry-in = op, so the core computes X + ~Y + 1.
- Operands are signed 5-bit (-16..15). rsp_wide is always the true signed 6-bit result.
- A requester must hold valid and operands stable until it is granted. Dropping valid before the grant is legal; that request is simply not served.
- No fairness starvation: a continuously asserted requester is served within NREQ transactions.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, and all rsp_* data outputs 0. Reset takes effect immediately (asynchronous).
- Latency: grant edge N, result registered at edge N+1, rsp_valid high from N+1 until the rsp_ready edge.
- Throughput: at best one operation per 3 cycles (IDLE, EXEC, RESP). The next grant is no earlier than the cycle after the response handshake.
- Response backpressure: rsp_ready low holds RESP indefinitely, with outputs unchanged.
- Simultaneous requests: only the round-robin winner is granted. The others keep waiting with ready=0.
- No valid in IDLE: remain in IDLE; ptr is unchanged.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is produced, and ptr returns to 0.

## Structure
- Package addsub_pkg:
  - W default
  - OP_ADD=1'b0, OP_SUB=1'b1
  - state enum {IDLE, EXEC, RESP}
  - response struct (id, sum, c4, c5, ovf, wide)
- Sub-module addsub5_core: purely combinational ripple-carry add/sub.
  - Inputs: x, y, op.
  - Outputs: s, c4, c5.
  - Built from per-bit full adders: S = a^b^c, Cout = majority.
- Top-level: FSM, round-robin pointer/priority encoder, operand and result registers.

## Test plan
- Add: requester 0, X=7, Y=5, op=0 -> S=01100, C4=0, C5=0, ovf=0, wide=001100 (12), id=0.
- Positive overflow: X=15, Y=15, op=0 -> S=11110, C4=1, C5=0, ovf=1, wide=011110 (+30).
- Subtract: X=3, Y=5, op=1 -> S=11110, C4=0, C5=0, ovf=0, wide=111110 (-2).
- Negative overflow: X=-16 (10000), Y=1, op=1 -> S=01111, C4=0, C5=1, ovf=1, wide=101111 (-17).
- Fairness: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. Each rsp_valid appears 1 cycle after its grant, and grants are spaced 3 cycles apart.
- Backpressure and reset: rsp_ready=0 for 10 cycles -> rsp outputs held and no req_ready asserted. Then assert rst_n=0 during RESP -> rsp_valid=0 immediately, and after release the first grant goes to the lowest-index valid requester (ptr=0).

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared width, opcode, FSM state and response types for the add/sub arbiter
package addsub_pkg;
  localparam int W = 5;
  localparam int IDW = 3;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           c4;
    logic           c5;
    logic           ovf;
    logic [W:0]     wide;
  } rsp_t;
endpackage

// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: requester handshakes plus the tagged response channel
interface addsub_arbiter_if #(parameter int NREQ = 4, parameter int W = 5);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_c4;
  logic              rsp_c5;
  logic              rsp_ovf;
  logic [W:0]        rsp_wide;
  modport master (
    output req_valid, req_x, req_y, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_c4, rsp_c5, rsp_ovf, rsp_wide
  );
  modport slave (
    input  req_valid, req_x, req_y, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_c4, rsp_c5, rsp_ovf, rsp_wide
  );
endinterface

// File: rtl/addsub5_core.sv
// addsub5_core: combinational ripple-carry add/subtract built from full adders
module addsub5_core #(parameter int W = addsub_pkg::W) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         op,
  output logic [W-1:0] s,
  output logic         c4,
  output logic         c5
);
  logic [W:0]   c;
  logic [W-1:0] b;
  // subtract as X + ~Y + 1
  assign b = y ^ {W{op}};
  assign c[0] = op;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i] = x[i] ^ b[i] ^ c[i];
    assign c[i+1] = (x[i] & b[i]) | (x[i] & c[i]) | (b[i] & c[i]);
  end
  assign c4 = c[W-1];
  assign c5 = c[W];
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sequencer sharing one add/sub core among NREQ requesters
module addsub_arbiter import addsub_pkg::*; #(
  parameter int NREQ = 4,
  parameter int W = addsub_pkg::W
) (
  input logic clk,
  input logic rst_n,
  addsub_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, gidx, cand;
  logic [W-1:0]  x_q, x_d, y_q, y_d, s;
  logic          op_q, op_d, c4, c5, ovf, gnt_any;
  rsp_t          rsp_q, rsp_d;
  addsub5_core #(.W(W)) u_core (.x(x_q), .y(y_q), .op(op_q), .s(s), .c4(c4), .c5(c5));
  assign ovf = c4 ^ c5;
  // scan downward so the candidate closest to ptr wins
  always_comb begin
    gnt_any = 1'b0;
    gidx = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gidx = cand;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    x_d = x_q;
    y_d = y_q;
    op_d = op_q;
    rsp_d = rsp_q;
    if (state_q == IDLE && gnt_any) begin
      state_d = EXEC;
      id_d = gidx;
      x_d = bus.req_x[gidx*W +: W];
      y_d = bus.req_y[gidx*W +: W];
      op_d = bus.req_op[gidx];
    end
    if (state_q == EXEC) begin
      state_d = RESP;
      rsp_d.id = IDW'(id_q);
      rsp_d.sum = s;
      rsp_d.c4 = c4;
      rsp_d.c5 = c5;
      rsp_d.ovf = ovf;
      rsp_d.wide = ovf ? {c5, s} : {s[W-1], s};
    end
    if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
      ptr_d = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      x_q <= '0;
      y_q <= '0;
      op_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      x_q <= x_d;
      y_q <= y_d;
      op_q <= op_d;
      rsp_q <= rsp_d;
    end
  end
  assign bus.req_ready = (rst_n && state_q == IDLE && gnt_any) ? NREQ'(1) << gidx : '0;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id = rsp_q.id[IW-1:0];
  assign bus.rsp_sum = rsp_q.sum;
  assign bus.rsp_c4 = rsp_q.c4;
  assign bus.rsp_c5 = rsp_q.c5;
  assign bus.rsp_ovf = rsp_q.ovf;
  assign bus.rsp_wide = rsp_q.wide;
endmodule
